// File: rtl/ibex_rvfi_trace_streamer.sv
// Captures RVFI retirements into a record FIFO and streams each record as a
// fixed 4-word packet (header, pc, insn, rd_wdata) on a 32-bit valid/ready port.
module ibex_rvfi_trace_streamer #(
  parameter int unsigned Depth = 16,
  parameter int unsigned LvlW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            clear_i,
  input  logic            rvfi_valid_i,
  input  logic [31:0]     rvfi_pc_rdata_i,
  input  logic [31:0]     rvfi_insn_i,
  input  logic [4:0]      rvfi_rd_addr_i,
  input  logic [31:0]     rvfi_rd_wdata_i,
  input  logic            rvfi_trap_i,
  input  logic            rvfi_intr_i,
  input  logic [3:0]      rvfi_mem_rmask_i,
  input  logic [3:0]      rvfi_mem_wmask_i,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [31:0]     trace_data_o,
  output logic            trace_last_o,
  output logic [LvlW-1:0] fifo_level_o,
  output logic            overflow_o
);

  localparam int unsigned PtrW     = $clog2(Depth);
  localparam logic [7:0]  SyncByte = 8'hA5;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_PC   = 2'd1;
  localparam logic [1:0] ST_INSN = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [7:0]      seq_q, seq_d;
  logic            overflow_q, overflow_d;

  // Header payload is stored without the constant sync byte.
  logic [23:0] hdr_mem   [Depth];
  logic [31:0] pc_mem    [Depth];
  logic [31:0] insn_mem  [Depth];
  logic [31:0] wdata_mem [Depth];

  logic empty, full, handshake, pop, offer, push, drop, mem_flag;
  logic [31:0] head_word;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LvlW'(Depth));
  assign handshake = ~empty & trace_ready_i;
  assign pop       = handshake & (state_q == ST_DATA);
  assign offer     = enable_i & rvfi_valid_i & ~clear_i;
  // A full FIFO still accepts a record if the head is leaving on the same edge.
  assign push      = offer & (~full | pop);
  assign drop      = offer & full & ~pop;
  assign mem_flag  = (|rvfi_mem_rmask_i) | (|rvfi_mem_wmask_i);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;

    if (clear_i) begin
      state_d    = ST_HDR;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      drop_cnt_d = '0;
      seq_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (handshake) begin
        unique case (state_q)
          ST_HDR:  state_d = ST_PC;
          ST_PC:   state_d = ST_INSN;
          ST_INSN: state_d = ST_DATA;
          default: state_d = ST_HDR;
        endcase
      end

      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        seq_d      = seq_q + 8'd1;
        drop_cnt_d = '0;
      end else if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      unique case ({push, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_HDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      hdr_mem[wr_ptr_q]   <= {drop_cnt_q, rvfi_rd_addr_i, rvfi_trap_i, rvfi_intr_i,
                              mem_flag, seq_q};
      pc_mem[wr_ptr_q]    <= rvfi_pc_rdata_i;
      insn_mem[wr_ptr_q]  <= rvfi_insn_i;
      wdata_mem[wr_ptr_q] <= rvfi_rd_wdata_i;
    end
  end

  // An empty FIFO presents a bare sync header so reset and clear look identical.
  always_comb begin
    head_word = {SyncByte, 24'h000000};
    if (!empty) begin
      unique case (state_q)
        ST_HDR:  head_word = {SyncByte, hdr_mem[rd_ptr_q]};
        ST_PC:   head_word = pc_mem[rd_ptr_q];
        ST_INSN: head_word = insn_mem[rd_ptr_q];
        default: head_word = wdata_mem[rd_ptr_q];
      endcase
    end
  end

  assign trace_valid_o = ~empty;
  assign trace_data_o  = head_word;
  assign trace_last_o  = ~empty & (state_q == ST_DATA);
  assign fifo_level_o  = level_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_streamer.sv
// Directed bench for ibex_rvfi_trace_streamer with a 4-entry FIFO.
module tb_ibex_rvfi_trace_streamer;

  localparam int unsigned Depth = 4;
  localparam int unsigned LvlW  = $clog2(Depth) + 1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic            enable_i = 1'b0;
  logic            clear_i = 1'b0;
  logic            rvfi_valid_i = 1'b0;
  logic [31:0]     rvfi_pc_rdata_i = '0;
  logic [31:0]     rvfi_insn_i = '0;
  logic [4:0]      rvfi_rd_addr_i = '0;
  logic [31:0]     rvfi_rd_wdata_i = '0;
  logic            rvfi_trap_i = 1'b0;
  logic            rvfi_intr_i = 1'b0;
  logic [3:0]      rvfi_mem_rmask_i = '0;
  logic [3:0]      rvfi_mem_wmask_i = '0;
  logic            trace_valid_o;
  logic            trace_ready_i = 1'b0;
  logic [31:0]     trace_data_o;
  logic            trace_last_o;
  logic [LvlW-1:0] fifo_level_o;
  logic            overflow_o;

  int checks = 0;
  int errors = 0;

  ibex_rvfi_trace_streamer #(.Depth(Depth)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_insn_i(rvfi_insn_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
    .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_trap_i(rvfi_trap_i),
    .rvfi_intr_i(rvfi_intr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
    .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o),
    .trace_last_o(trace_last_o), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // All tasks enter and leave 1ns after a rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn,
                        input logic [4:0] rd, input logic [31:0] wdata,
                        input logic trap, input logic intr,
                        input logic [3:0] rmask, input logic [3:0] wmask);
    rvfi_valid_i     = 1'b1;
    rvfi_pc_rdata_i  = pc;
    rvfi_insn_i      = insn;
    rvfi_rd_addr_i   = rd;
    rvfi_rd_wdata_i  = wdata;
    rvfi_trap_i      = trap;
    rvfi_intr_i      = intr;
    rvfi_mem_rmask_i = rmask;
    rvfi_mem_wmask_i = wmask;
    tick();
    rvfi_valid_i     = 1'b0;
    rvfi_trap_i      = 1'b0;
    rvfi_intr_i      = 1'b0;
    rvfi_mem_rmask_i = '0;
    rvfi_mem_wmask_i = '0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", trace_valid_o); end
    checks++; if (trace_last_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b exp 0", trace_last_o); end
    checks++; if (trace_data_o !== 32'hA5000000) begin errors++; $display("[TB] FAIL reset_data got %h exp a5000000", trace_data_o); end
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d exp 0", fifo_level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b exp 0", overflow_o); end
  endtask

  task automatic test_single_record();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hA5000800;
    exp_w[1] = 32'h00000100;
    exp_w[2] = 32'h00500093;
    exp_w[3] = 32'h00000005;
    trace_ready_i = 1'b1;
    retire(32'h100, 32'h00500093, 5'd1, 32'h5, 1'b0, 1'b0, 4'h0, 4'h0);
    checks++; if (fifo_level_o !== 3'd1) begin errors++; $display("[TB] FAIL single_level got %0d exp 1", fifo_level_o); end
    for (int w = 0; w < 4; w++) begin
      checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_w%0d got %b exp 1", w, trace_valid_o); end
      checks++; if (trace_data_o !== exp_w[w]) begin errors++; $display("[TB] FAIL single_data_w%0d got %h exp %h", w, trace_data_o, exp_w[w]); end
      checks++; if (trace_last_o !== (w == 3)) begin errors++; $display("[TB] FAIL single_last_w%0d got %b exp %b", w, trace_last_o, (w == 3)); end
      tick();
    end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got %b exp 0", trace_valid_o); end
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL single_level_end got %0d exp 0", fifo_level_o); end
  endtask

  task automatic test_enable();
    enable_i = 1'b0;
    retire(32'h180, 32'h13, 5'd4, 32'h1, 1'b0, 1'b0, 4'h0, 4'h0);
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL enable_level got %0d exp 0", fifo_level_o); end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL enable_valid got %b exp 0", trace_valid_o); end
    enable_i = 1'b1;
  endtask

  task automatic test_flags();
    retire(32'h300, 32'h13, 5'd0, 32'h0, 1'b1, 1'b0, 4'b0001, 4'b0000);
    checks++; if (trace_data_o !== 32'hA5000501) begin errors++; $display("[TB] FAIL flags_trap_mem got %h exp a5000501", trace_data_o); end
    repeat (4) tick();
    retire(32'h304, 32'h13, 5'd0, 32'h0, 1'b0, 1'b1, 4'b0000, 4'b1000);
    checks++; if (trace_data_o !== 32'hA5000302) begin errors++; $display("[TB] FAIL flags_intr_mem got %h exp a5000302", trace_data_o); end
    repeat (4) tick();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flags_drained got %b exp 0", trace_valid_o); end
  endtask

  task automatic test_backpressure();
    trace_ready_i = 1'b1;
    retire(32'h200, 32'h11, 5'd2, 32'h22, 1'b0, 1'b0, 4'h0, 4'h0);
    checks++; if (trace_data_o !== 32'hA5001003) begin errors++; $display("[TB] FAIL bp_hdr got %h exp a5001003", trace_data_o); end
    tick();
    checks++; if (trace_data_o !== 32'h200) begin errors++; $display("[TB] FAIL bp_pc got %h exp 00000200", trace_data_o); end
    tick();
    checks++; if (trace_data_o !== 32'h11) begin errors++; $display("[TB] FAIL bp_insn got %h exp 00000011", trace_data_o); end
    trace_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (trace_data_o !== 32'h11 || trace_last_o !== 1'b0 || trace_valid_o !== 1'b1)
        begin errors++; $display("[TB] FAIL bp_hold_c%0d got data %h last %b valid %b exp 00000011 0 1", c, trace_data_o, trace_last_o, trace_valid_o); end
    end
    trace_ready_i = 1'b1;
    tick();
    checks++; if (trace_data_o !== 32'h22 || trace_last_o !== 1'b1)
      begin errors++; $display("[TB] FAIL bp_data got %h last %b exp 00000022 1", trace_data_o, trace_last_o); end
    tick();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got %b exp 0", trace_valid_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    trace_ready_i = 1'b0;
    rvfi_valid_i  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rvfi_pc_rdata_i = 32'h1000 + 32'(4 * i);
      rvfi_insn_i     = 32'(i);
      rvfi_rd_addr_i  = 5'(i);
      rvfi_rd_wdata_i = ~32'(i);
      tick();
    end
    rvfi_valid_i = 1'b0;
    checks++; if (fifo_level_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level got %0d exp 4", fifo_level_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b exp 1", overflow_o); end
    trace_ready_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 4; w++) begin
        case (w)
          0: exp = {8'hA5, 8'h00, 5'(p), 3'b000, 8'(4 + p)};
          1: exp = 32'h1000 + 32'(4 * p);
          2: exp = 32'(p);
          default: exp = ~32'(p);
        endcase
        checks++; if (trace_data_o !== exp || trace_last_o !== (w == 3))
          begin errors++; $display("[TB] FAIL ovf_drain_p%0d_w%0d got %h last %b exp %h last %b", p, w, trace_data_o, trace_last_o, exp, (w == 3)); end
        tick();
      end
    end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained got %b exp 0", trace_valid_o); end
    retire(32'h2000, 32'h99, 5'd7, 32'h77, 1'b0, 1'b0, 4'h0, 4'h0);
    checks++; if (trace_data_o !== 32'hA5033808) begin errors++; $display("[TB] FAIL ovf_drops_hdr got %h exp a5033808", trace_data_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b exp 1", overflow_o); end
    repeat (4) tick();
  endtask

  task automatic test_saturation();
    do_clear();
    checks++; if (overflow_o !== 1'b0 || fifo_level_o !== 3'd0 || trace_valid_o !== 1'b0)
      begin errors++; $display("[TB] FAIL sat_clear got ovf %b level %0d valid %b exp 0 0 0", overflow_o, fifo_level_o, trace_valid_o); end
    trace_ready_i   = 1'b0;
    rvfi_rd_addr_i  = 5'd0;
    rvfi_valid_i    = 1'b1;
    repeat (304) tick();
    rvfi_valid_i = 1'b0;
    checks++; if (fifo_level_o !== 3'd4 || overflow_o !== 1'b1)
      begin errors++; $display("[TB] FAIL sat_full got level %0d ovf %b exp 4 1", fifo_level_o, overflow_o); end
    trace_ready_i = 1'b1;
    repeat (16) tick();
    retire(32'h3000, 32'h13, 5'd0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    checks++; if (trace_data_o !== 32'hA5FF0004) begin errors++; $display("[TB] FAIL sat_hdr got %h exp a5ff0004", trace_data_o); end
    repeat (4) tick();
  endtask

  task automatic test_seq_wrap();
    logic [31:0] exp;
    do_clear();
    trace_ready_i = 1'b1;
    for (int k = 0; k < 258; k++) begin
      retire(32'(4 * k), 32'(k), 5'd31, 32'(k), 1'b0, 1'b0, 4'h0, 4'h0);
      exp = {8'hA5, 8'h00, 5'd31, 3'b000, 8'(k)};
      checks++; if (trace_data_o !== exp) begin errors++; $display("[TB] FAIL seq_k%0d got %h exp %h", k, trace_data_o, exp); end
      repeat (3) tick();
    end
    tick();
    checks++; if (trace_valid_o !== 1'b0 || overflow_o !== 1'b0)
      begin errors++; $display("[TB] FAIL seq_end got valid %b ovf %b exp 0 0", trace_valid_o, overflow_o); end
  endtask

  task automatic test_full_simul_pop();
    logic [4:0] exp_rd [4];
    logic [31:0] exp;
    exp_rd[0] = 5'd2; exp_rd[1] = 5'd3; exp_rd[2] = 5'd4; exp_rd[3] = 5'd9;
    do_clear();
    trace_ready_i = 1'b0;
    rvfi_valid_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rvfi_rd_addr_i = 5'(i + 1);
      tick();
    end
    rvfi_valid_i = 1'b0;
    checks++; if (fifo_level_o !== 3'd4 || overflow_o !== 1'b0)
      begin errors++; $display("[TB] FAIL fsp_fill got level %0d ovf %b exp 4 0", fifo_level_o, overflow_o); end
    trace_ready_i = 1'b1;
    repeat (3) tick();
    checks++; if (trace_last_o !== 1'b1) begin errors++; $display("[TB] FAIL fsp_at_data got last %b exp 1", trace_last_o); end
    rvfi_valid_i   = 1'b1;
    rvfi_rd_addr_i = 5'd9;
    tick();
    rvfi_valid_i = 1'b0;
    checks++; if (fifo_level_o !== 3'd4 || overflow_o !== 1'b0)
      begin errors++; $display("[TB] FAIL fsp_level got level %0d ovf %b exp 4 0", fifo_level_o, overflow_o); end
    for (int p = 0; p < 4; p++) begin
      exp = {8'hA5, 8'h00, exp_rd[p], 3'b000, 8'(p + 1)};
      checks++; if (trace_data_o !== exp) begin errors++; $display("[TB] FAIL fsp_hdr_p%0d got %h exp %h", p, trace_data_o, exp); end
      repeat (4) tick();
    end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fsp_drained got %b exp 0", trace_valid_o); end
  endtask

  task automatic fill_with_drop();
    trace_ready_i   = 1'b0;
    rvfi_pc_rdata_i = 32'h4000;
    rvfi_rd_addr_i  = 5'd0;
    rvfi_valid_i    = 1'b1;
    repeat (5) tick();
    rvfi_valid_i  = 1'b0;
    trace_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_clear();
    fill_with_drop();
    checks++; if (trace_data_o !== 32'h4000 || overflow_o !== 1'b1)
      begin errors++; $display("[TB] FAIL rst_pre got %h ovf %b exp 00004000 1", trace_data_o, overflow_o); end
    #2 rst_ni = 1'b0;
    #1;
    test_reset();
    #1 rst_ni = 1'b1;
    tick();
    retire(32'h5000, 32'h13, 5'd3, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    checks++; if (trace_data_o !== 32'hA5001800) begin errors++; $display("[TB] FAIL rst_post_hdr got %h exp a5001800", trace_data_o); end
    repeat (4) tick();
  endtask

  task automatic test_clear_mid_packet();
    fill_with_drop();
    checks++; if (trace_data_o !== 32'h4000 || overflow_o !== 1'b1)
      begin errors++; $display("[TB] FAIL clr_pre got %h ovf %b exp 00004000 1", trace_data_o, overflow_o); end
    clear_i      = 1'b1;
    rvfi_valid_i = 1'b1;
    tick();
    clear_i      = 1'b0;
    rvfi_valid_i = 1'b0;
    test_reset();
    retire(32'h5000, 32'h13, 5'd3, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    checks++; if (trace_data_o !== 32'hA5001800) begin errors++; $display("[TB] FAIL clr_post_hdr got %h exp a5001800", trace_data_o); end
    repeat (4) tick();
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    tick();
    tick();
    test_reset();
    rst_ni   = 1'b1;
    enable_i = 1'b1;
    tick();
    test_single_record();
    test_enable();
    test_flags();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_seq_wrap();
    test_full_simul_pop();
    test_reset_mid_packet();
    test_clear_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
